// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronizes and debounces a raw button level into a clean level
//            plus one-cycle press/release strobes. Optional auto-repeat strobe
//            enabled by defining BUTTON_DEBOUNCER_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 ||
            REPEAT_PERIOD < 1 || $clog2(DEBOUNCE_CYCLES) > CNT_W ||
            $clog2(REPEAT_DELAY) > CNT_W || $clog2(REPEAT_PERIOD) > CNT_W) begin : g_bad_params
            $error("button_debouncer: illegal parameter combination");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    state_t                 r_state;
    logic                   w_sync;
    logic                   w_rise_accept;
    logic                   w_fall_accept;

    assign w_sync        = r_sync[SYNC_STAGES-1];
    assign w_rise_accept = (r_state == RISE_CHK) && w_sync  && (r_cnt == c_deb_last);
    assign w_fall_accept = (r_state == FALL_CHK) && !w_sync && (r_cnt == c_deb_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_cnt       <= '0;
            r_state     <= LOW;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], btn_in};
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (r_state)
                LOW: begin
                    if (w_sync) begin
                        r_state <= RISE_CHK;
                        r_cnt   <= '0;
                    end
                end
                RISE_CHK: begin
                    // Any reversal during the check throws away the count.
                    if (!w_sync) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (w_rise_accept) begin
                        r_state   <= HIGH;
                        r_cnt     <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                HIGH: begin
                    if (!w_sync) begin
                        r_state <= FALL_CHK;
                        r_cnt   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (w_sync) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (w_fall_accept) begin
                        r_state     <= LOW;
                        r_cnt       <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_rcnt;
    logic             r_rfirst;

    // Timing runs through FALL_CHK so a rejected release glitch keeps the cadence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt     <= '0;
            r_rfirst   <= 1'b1;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            if (w_rise_accept || w_fall_accept) begin
                r_rcnt   <= '0;
                r_rfirst <= 1'b1;
            end else if (r_state == HIGH || r_state == FALL_CHK) begin
                if (r_rcnt == (r_rfirst ? c_delay_last : c_period_last)) begin
                    r_rcnt     <= '0;
                    r_rfirst   <= 1'b0;
                    btn_repeat <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + c_one;
                end
            end else begin
                r_rcnt   <= '0;
                r_rfirst <= 1'b1;
            end
        end
    end
`else
    assign btn_repeat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Scoreboard bench; stimulus queues expected strobes, a negedge
//            monitor pops and compares them as the DUT emits strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int LAT       = 7;
    localparam int RD        = 8;
    localparam int RP        = 3;
    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_REPEAT  = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_repeat;

    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   c_base;
    int   mon_code;
    ev_t  mon_ev;
    ev_t  q[$];

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected press at p, auto-repeats strictly before the release edge r, release at r.
    task automatic push_pulse(input int p, input int r);
        q.push_back('{K_PRESS, p});
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        for (int t = p + RD; t < r; t += RP) q.push_back('{K_REPEAT, t});
`endif
        q.push_back('{K_RELEASE, r});
    endtask

    task automatic run_pulse(input int hold);
        push_pulse(cyc + LAT, cyc + hold + LAT);
        btn_in = 1'b1;
        tick(hold);
        if (hold >= LAT) chk("level_while_held", btn_level, 1);
        btn_in = 1'b0;
        tick(15);
        chk("level_after_release", btn_level, 0);
    endtask

    always @(negedge clk) begin
        mon_code = int'({btn_repeat, btn_release, btn_press});
        if (mon_code != 0) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", mon_code, 0);
            end else begin
                mon_ev = q.pop_front();
                chk("strobe_kind", mon_code, mon_ev.kind);
                chk("strobe_edge", cyc, mon_ev.cyc);
                chk("level_with_strobe", int'(btn_level), (mon_ev.kind == K_RELEASE) ? 0 : 1);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_level",   btn_level,   0);
            chk("reset_press",   btn_press,   0);
            chk("reset_release", btn_release, 0);
            chk("reset_repeat",  btn_repeat,  0);
        end

        // Input already high when reset drops.
        rst = 1'b0;
        push_pulse(cyc + LAT, cyc + 15 + LAT);
        tick(15);
        chk("level_after_reset_press", btn_level, 1);
        btn_in = 1'b0;
        tick(15);
        chk("level_after_first_release", btn_level, 0);

        // Clean press/release.
        run_pulse(20);

        // Bounce on the way up: only the final rise is accepted.
        c_base = cyc;
        push_pulse(c_base + 8 + LAT, c_base + 23 + LAT);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(2);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(15);
        chk("level_after_bounce", btn_level, 1);
        btn_in = 1'b0;
        tick(15);
        chk("level_after_bounce_release", btn_level, 0);

        // Glitches of 3 and 4 cycles are rejected; 5 cycles is the shortest accepted.
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0; tick(15);
        chk("level_after_glitch3", btn_level, 0);
        btn_in = 1'b1; tick(4);
        btn_in = 1'b0; tick(15);
        chk("level_after_glitch4", btn_level, 0);
        run_pulse(5);

        // Reset while held high: no release, fresh press afterwards.
        q.push_back('{K_PRESS, cyc + LAT});
        btn_in = 1'b1;
        tick(12);
        chk("level_before_midhold_reset", btn_level, 1);
        rst = 1'b1;
        tick(1);
        chk("midhold_reset_level",   btn_level,   0);
        chk("midhold_reset_press",   btn_press,   0);
        chk("midhold_reset_release", btn_release, 0);
        rst = 1'b0;
        push_pulse(cyc + LAT, cyc + 15 + LAT);
        tick(15);
        chk("level_after_reset_repress", btn_level, 1);
        btn_in = 1'b0;
        tick(15);
        chk("level_after_reset_rerelease", btn_level, 0);

        // Short dip while held is rejected and does not disturb repeat timing.
        c_base = cyc;
        push_pulse(c_base + LAT, c_base + 22 + LAT);
        btn_in = 1'b1; tick(10);
        btn_in = 1'b0; tick(2);
        btn_in = 1'b1; tick(10);
        chk("level_after_dip", btn_level, 1);
        btn_in = 1'b0;
        tick(15);
        chk("level_after_dip_release", btn_level, 0);

        // Long hold for auto-repeat.
        run_pulse(30);

        tick(5);
        chk("pending_expected_strobes", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw mechanical input (start/stop button, mode button, switch) into a clean level plus single-cycle press/release strobes.
- Sits between the board pin and the start_stop counter control logic, upstream of that logic.
- Absorbs bounce and glitches so the counter logic sees exactly one event per physical actuation.
- One instance per button; all instances share the system clock.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer chain; minimum 2.
- DEBOUNCE_CYCLES, 1000, consecutive cycles the synchronized input must hold a new value before it is accepted; minimum 2.
- CNT_W, 16, width of the debounce and repeat counters; must hold DEBOUNCE_CYCLES-1, REPEAT_DELAY-1 and REPEAT_PERIOD-1.
- REPEAT_DELAY, 50000, hold cycles before the first auto-repeat strobe; used only with the optional feature.
- REPEAT_PERIOD, 10000, cycles between later auto-repeat strobes; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button/switch level; 1 = pressed.
- btn_level  output  1  debounced level.
- btn_press  output  1  one-cycle strobe on an accepted 0->1 transition.
- btn_release  output  1  one-cycle strobe on an accepted 1->0 transition.
- btn_repeat  output  1  one-cycle auto-repeat strobe; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clock edge):
  - synchronizer flops, counters, state and all outputs go to 0; state = LOW.
  - Reset mid-bounce or mid-hold discards all progress; no strobe is emitted in the reset cycle or the cycle after.
- Synchronizer:
  - btn_in passes through SYNC_STAGES flops; the result is btn_sync.
  - No other logic samples btn_in directly.
- States: LOW, RISE_CHK, HIGH, FALL_CHK.
  - LOW: btn_sync=1 -> go to RISE_CHK with cnt=0.
  - RISE_CHK:
    - btn_sync=0 -> back to LOW with cnt=0, no strobe (glitch rejected).
    - btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> go to HIGH; btn_level=1 and btn_press=1 for one cycle.
    - otherwise cnt increments.
  - HIGH: btn_sync=0 -> go to FALL_CHK with cnt=0.
  - FALL_CHK: mirror of RISE_CHK.
    - btn_sync=1 -> back to HIGH, no strobe.
    - terminal count -> go to LOW; btn_level=0 and btn_release=1 for one cycle.
- Latency:
  - Accepted change = SYNC_STAGES + DEBOUNCE_CYCLES + 1 clock edges from the first edge that samples the new btn_in level.
  - btn_level and its strobe update on the same edge.
- Glitch rejection:
  - Any excursion on btn_sync lasting fewer than DEBOUNCE_CYCLES+1 cycles produces no change and no strobe.
  - Bounce restarts the count from 0 on every reversal.
- Strobe timing:
  - btn_press and btn_release are never high in the same cycle.
  - Each is high for exactly one cycle per accepted transition.
- Input high at reset release: debounced normally, so btn_press fires after the full latency.
- All outputs are registered; no combinational path from btn_in to any output.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_REPEAT_EN.
- Defined:
  - In HIGH, a repeat counter starts at 0 on entry.
  - btn_repeat pulses one cycle after REPEAT_DELAY cycles in HIGH, then every REPEAT_PERIOD cycles while the state stays HIGH or FALL_CHK.
  - Entering LOW, or reset, clears the repeat counter.
  - A FALL_CHK that aborts back to HIGH does not restart the repeat timing.
  - btn_repeat never coincides with btn_press.
- Not defined: btn_repeat is constant 0, the repeat counter and parameters are unused, and the port remains present.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, 10 ns clock):
- Reset: rst=1 for 3 cycles with btn_in=1 -> all outputs 0 during reset; btn_press pulses once, 7 edges after rst deasserts; btn_level=1 from then on.
- Clean press/release: btn_in 0->1, held 20 cycles, then 1->0 -> one btn_press and one btn_release, each 1 cycle wide; each 7 edges after its input change; btn_level=1 between them.
- Bounce: btn_in toggles 1,0,1,0 at 2-cycle intervals, then stays 1 -> single btn_press, 7 edges after the final 0->1; no btn_release.
- Glitch: btn_in high for 3 cycles, then low -> no strobe; btn_level stays 0.
- Reset mid-hold: btn_level=1, then rst pulsed for 1 cycle while btn_in=1 -> outputs 0, no btn_release emitted, fresh btn_press 7 edges after rst drops.
- Repeat (macro defined): hold btn_in=1 for 30 cycles after press -> btn_repeat at press+8, +11, +14 and so on; none after release is accepted. Macro undefined -> btn_repeat always 0.
